// File: rtl/banco_registradores.sv
// 32 x BITS integer register file: two combinational read ports with write bypass, one write port, pending scoreboard.
// Reads and flags are zero-latency and writes land on the next clk edge; there is no backpressure, and dependent reads stall via hazard.
module banco_registradores #(
    parameter int BITS = 64,
    parameter int REGS = 32,
    parameter int ADDR = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ADDR-1:0] rs1,
    input  logic [ADDR-1:0] rs2,
    output logic [BITS-1:0] douta,
    output logic [BITS-1:0] doutb,
    input  logic            we,
    input  logic [ADDR-1:0] rd,
    input  logic [BITS-1:0] din,
    input  logic            res_en,
    input  logic [ADDR-1:0] res_addr,
    output logic            pendente_a,
    output logic            pendente_b,
    output logic            hazard
);

    logic [BITS-1:0] regs [REGS];
    logic [REGS-1:0] pend;

    logic wr_vld;
    logic res_vld;

    assign wr_vld  = we && (rd != '0);
    assign res_vld = res_en && (res_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_vld) begin
            regs[rd] <= din;
        end
    end

    // A reserve in the same cycle as a write to that register wins: the new producer supersedes the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend[0] <= 1'b0;
            for (int i = 1; i < REGS; i++) begin
                if (res_vld && (res_addr == ADDR'(i))) begin
                    pend[i] <= 1'b1;
                end else if (wr_vld && (rd == ADDR'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Outputs are forced to zero while reset is held, so a bypassed din cannot leak through.
    assign douta = (!rst_n || rs1 == '0) ? '0 :
                   (we && rd == rs1)     ? din : regs[rs1];
    assign doutb = (!rst_n || rs2 == '0) ? '0 :
                   (we && rd == rs2)     ? din : regs[rs2];

    assign pendente_a = rst_n && pend[rs1] &&
                        !(we && rd == rs1 && !(res_en && res_addr == rs1));
    assign pendente_b = rst_n && pend[rs2] &&
                        !(we && rd == rs2 && !(res_en && res_addr == rs2));
    assign hazard     = pendente_a || pendente_b;

endmodule

// File: tb/tb_banco_registradores.sv
// Directed bench for banco_registradores: reset, read/write, bypass, x0, scoreboard, async reset.
module tb_banco_registradores;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd, res_addr;
    logic [63:0] douta, doutb, din;
    logic        we, res_en;
    logic        pendente_a, pendente_b, hazard;

    int n_cmp = 0;
    int n_err = 0;

    banco_registradores #(.BITS(64), .REGS(32), .ADDR(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1(rs1), .rs2(rs2), .douta(douta), .doutb(doutb),
        .we(we), .rd(rd), .din(din),
        .res_en(res_en), .res_addr(res_addr),
        .pendente_a(pendente_a), .pendente_b(pendente_b), .hazard(hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; res_en = 1'b0;
        rs1 = 5'd5; rs2 = 5'd7; rd = 5'd0; res_addr = 5'd0; din = '0;
        #3;
        check("rst_douta", douta, 64'h0);
        check("rst_doutb", doutb, 64'h0);
        check("rst_hazard", {63'b0, hazard}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_douta", douta, 64'h0);

        // write then read on both ports
        step();
        we = 1'b1; rd = 5'd3; din = 64'hDEADBEEF_00000001;
        step();
        we = 1'b0; rs1 = 5'd3; rs2 = 5'd3;
        #1;
        check("wr_douta", douta, 64'hDEADBEEF_00000001);
        check("wr_doutb", doutb, 64'hDEADBEEF_00000001);

        // bypass
        we = 1'b1; rd = 5'd7; din = 64'h10;
        step();
        we = 1'b0; rs1 = 5'd7;
        #1;
        check("byp_old", douta, 64'h10);
        we = 1'b1; rd = 5'd7; din = 64'h20;
        #1;
        check("byp_before", douta, 64'h20);
        step();
        we = 1'b0;
        #1;
        check("byp_after", douta, 64'h20);

        // x0 hardwired
        we = 1'b1; rd = 5'd0; din = '1; res_en = 1'b1; res_addr = 5'd0; rs1 = 5'd0;
        #1;
        check("x0_douta_comb", douta, 64'h0);
        check("x0_pend_comb", {63'b0, pendente_a}, 64'd0);
        step();
        check("x0_douta_edge", douta, 64'h0);
        we = 1'b0; res_en = 1'b0;
        step();
        check("x0_douta_later", douta, 64'h0);
        check("x0_pend_later", {63'b0, pendente_a}, 64'd0);

        // scoreboard reserve and release
        res_en = 1'b1; res_addr = 5'd9;
        step();
        res_en = 1'b0; rs2 = 5'd9;
        #1;
        check("sb_pend_b", {63'b0, pendente_b}, 64'd1);
        check("sb_hazard", {63'b0, hazard}, 64'd1);
        we = 1'b1; rd = 5'd9; din = 64'h55;
        #1;
        check("sb_rel_comb", {63'b0, pendente_b}, 64'd0);
        check("sb_rel_doutb", doutb, 64'h55);
        check("sb_rel_hazard", {63'b0, hazard}, 64'd0);
        step();
        we = 1'b0;
        #1;
        check("sb_rel_after", {63'b0, pendente_b}, 64'd0);
        check("sb_doutb_after", doutb, 64'h55);

        // simultaneous reserve and release of the same register
        res_en = 1'b1; res_addr = 5'd4;
        step();
        res_en = 1'b0; rs1 = 5'd4;
        #1;
        check("sim_pend_pre", {63'b0, pendente_a}, 64'd1);
        we = 1'b1; rd = 5'd4; din = 64'h99; res_en = 1'b1; res_addr = 5'd4;
        #1;
        check("sim_pend_comb", {63'b0, pendente_a}, 64'd1);
        check("sim_douta_comb", douta, 64'h99);
        step();
        we = 1'b0; res_en = 1'b0;
        #1;
        check("sim_pend_after", {63'b0, pendente_a}, 64'd1);
        check("sim_douta_after", douta, 64'h99);

        // reserve x10 while releasing x4
        res_en = 1'b1; res_addr = 5'd10; we = 1'b1; rd = 5'd4; din = 64'hAA;
        step();
        res_en = 1'b0; we = 1'b0; rs1 = 5'd4; rs2 = 5'd10;
        #1;
        check("diff_pend_a", {63'b0, pendente_a}, 64'd0);
        check("diff_pend_b", {63'b0, pendente_b}, 64'd1);
        check("diff_douta", douta, 64'hAA);

        // re-reserve keeps pending without counting; one write releases
        res_en = 1'b1; res_addr = 5'd10;
        step();
        res_en = 1'b0;
        #1;
        check("rereserve_pend", {63'b0, pendente_b}, 64'd1);
        we = 1'b1; rd = 5'd10; din = 64'h1;
        step();
        we = 1'b0;
        #1;
        check("single_release", {63'b0, pendente_b}, 64'd0);

        // async reset mid-cycle
        res_en = 1'b1; res_addr = 5'd4; we = 1'b1; rd = 5'd5; din = 64'h1234;
        step();
        res_en = 1'b0; we = 1'b0; rs1 = 5'd5; rs2 = 5'd4;
        #1;
        check("ar_douta_pre", douta, 64'h1234);
        check("ar_pend_b_pre", {63'b0, pendente_b}, 64'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_douta", douta, 64'h0);
        check("ar_pend_a", {63'b0, pendente_a}, 64'd0);
        check("ar_pend_b", {63'b0, pendente_b}, 64'd0);
        check("ar_hazard", {63'b0, hazard}, 64'd0);
        we = 1'b1; rd = 5'd5; din = 64'h77; res_en = 1'b1; res_addr = 5'd5;
        #1;
        check("ar_held_byp", douta, 64'h0);
        step();
        @(negedge clk);
        we = 1'b0; res_en = 1'b0;
        rst_n = 1'b1;
        rs1 = 5'd5; rs2 = 5'd3;
        #1;
        check("ar_clean_x5", douta, 64'h0);
        check("ar_clean_x3", doutb, 64'h0);
        check("ar_clean_pend", {63'b0, pendente_a}, 64'd0);
        rs2 = 5'd4;
        #1;
        check("ar_clean_x4_pend", {63'b0, pendente_b}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
